mode_limit_counter: RTL

MODE_LIMIT_COUNTER -- requirements
Module: mode_limit_counter

---
 rtl/counter_pkg.sv | 28 ++
 rtl/mode_limit_lut.sv | 16 +
 rtl/mode_limit_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared state type, default sizes and mode-to-limit table for mode_limit_counter.
package counter_pkg;

  localparam int unsigned DEF_WIDTH  = 32'd5;
  localparam int unsigned DEF_MODE_W = 32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // Full-width limit per mode; callers truncate to their count width.
  function automatic logic [31:0] mode_limit(input logic [31:0] mode);
    logic [31:0] lim;
    case (mode)
      32'd0:   lim = 32'd0;
      32'd1:   lim = 32'd6;
      32'd2:   lim = 32'd0;
      32'd3:   lim = 32'd11;
      32'd4:   lim = 32'd5;
      32'd5:   lim = 32'd16;
      default: lim = 32'd0;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/mode_limit_lut.sv
// Combinational mode-to-limit lookup, truncated to the counter width.
module mode_limit_lut
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MODE_W = DEF_MODE_W
) (
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  limit
);

  always_comb begin
    limit = WIDTH'(mode_limit(32'(mode)));
  end

endmodule

// File: rtl/mode_limit_counter.sv
// Mode-selected wrap-around up/down counter with IDLE/RUN/PAUSE control.
// The limit is looked up from the registered mode and registered once more.
module mode_limit_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MODE_W = DEF_MODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              dir,
  output logic [WIDTH-1:0]  count,
  output logic [WIDTH-1:0]  max_num,
  output logic              wrap,
  output logic              busy,
  output logic              err
);

  state_e              state_q, state_d;
  logic [MODE_W-1:0]   mode_q;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    max_num_q, max_num_d;
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [WIDTH-1:0]    lim_s;
  logic                mode_chg_s;

  mode_limit_lut #(
    .WIDTH  (WIDTH),
    .MODE_W (MODE_W)
  ) u_lut (
    .mode  (mode_q),
    .limit (lim_s)
  );

  // Start is qualified with the live lookup of mode_q so a zero-limit mode never enters RUN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    mode_chg_s = (mode != mode_q);
    max_num_d  = lim_s;
    err_d      = (lim_s == {WIDTH{1'b0}});

    if (clear) begin
      state_d = ST_IDLE;
      count_d = {WIDTH{1'b0}};
    end else if (mode_chg_s) begin
      state_d = ST_IDLE;
      count_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!stop && start && (lim_s != {WIDTH{1'b0}})) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (count_q > max_num_q) begin
            count_d = {WIDTH{1'b0}};
            wrap_d  = 1'b1;
          end else if (!dir) begin
            if (count_q == max_num_q) begin
              count_d = {WIDTH{1'b0}};
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1'b1);
            end
          end else begin
            if (count_q == {WIDTH{1'b0}}) begin
              count_d = max_num_q;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1'b1);
            end
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  // State and output registers; reset forces the invalid-mode-0 view (err high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= {MODE_W{1'b0}};
      count_q   <= {WIDTH{1'b0}};
      max_num_q <= {WIDTH{1'b0}};
      wrap_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode;
      count_q   <= count_d;
      max_num_q <= max_num_d;
      wrap_q    <= wrap_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign count   = count_q;
  assign max_num = max_num_q;
  assign wrap    = wrap_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
